// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and CPU reset release
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES         = 3,
  parameter int RC_W                = 2
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            soft_reset_req,
  output logic            pll_rst,
  output logic            cpu_rst,
  output logic            ready,
  output logic            fault,
  output logic [RC_W-1:0] retry_count,
  output logic [2:0]      seq_state
);

  localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             sync1_q, lock_s_q;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    if (soft_reset_req) begin
      state_d = S_HOLD;
      if (state_q == S_FAULT) rc_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle wins; no retry is charged.
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (rc_q == RC_MAX) begin
              state_d = S_FAULT;
            end else begin
              rc_d    = rc_q + 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            rc_d    = '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) state_d = S_HOLD;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_HOLD;
      endcase
    end

    // RUN and FAULT have no terminal count, so the counter parks there.
    if (soft_reset_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) || (state_q == S_FAULT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      rc_q        <= '0;
      pll_rst     <= 1'b1;
      cpu_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      seq_state   <= 3'd0;
    end else begin
      sync1_q     <= pll_locked;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rc_q        <= rc_d;
      // Outputs decode the next state so they move on the same edge as state_q.
      pll_rst     <= (state_d == S_HOLD) || (state_d == S_FAULT);
      cpu_rst     <= (state_d != S_RUN);
      ready       <= (state_d == S_RUN);
      fault       <= (state_d == S_FAULT);
      retry_count <= rc_d;
      seq_state   <= state_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int HOLD = 0, WAIT = 1, STAB = 2, RUN = 3, FLT = 4;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic rst, lock_a, soft_a, lock_b, soft_b;
  logic pll_rst_a, cpu_rst_a, ready_a, fault_a, pll_rst_b, cpu_rst_b, ready_b, fault_b;
  logic [1:0] rc_a, rc_b;
  logic [2:0] st_a, st_b;
  logic [8:0] obs [2];

  int checks = 0;
  int failures = 0;
  int ec = 0;

  // Instance 0 uses defaults; instance 1 is the short-timeout configuration.
  int p_hold [2] = '{16, 4};
  int p_stab [2] = '{64, 64};
  int p_tmo  [2] = '{4096, 32};
  int p_maxr [2] = '{3, 2};

  int m_state [2];
  int m_enter [2];
  int m_rc    [2];
  bit m_s1    [2];
  bit m_s2    [2];

  pll_reset_sequencer u_dut_a (
    .refclk(refclk), .rst(rst), .pll_locked(lock_a), .soft_reset_req(soft_a),
    .pll_rst(pll_rst_a), .cpu_rst(cpu_rst_a), .ready(ready_a), .fault(fault_a),
    .retry_count(rc_a), .seq_state(st_a)
  );

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(64), .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2), .RC_W(2)
  ) u_dut_b (
    .refclk(refclk), .rst(rst), .pll_locked(lock_b), .soft_reset_req(soft_b),
    .pll_rst(pll_rst_b), .cpu_rst(cpu_rst_b), .ready(ready_b), .fault(fault_b),
    .retry_count(rc_b), .seq_state(st_b)
  );

  assign obs[0] = {pll_rst_a, cpu_rst_a, ready_a, fault_a, rc_a, st_a};
  assign obs[1] = {pll_rst_b, cpu_rst_b, ready_b, fault_b, rc_b, st_b};

  // Time spent in a state is measured as edges since the state was entered.
  function automatic void model_step(int i, bit r, bit lk, bit sf);
    bit ls;
    int el, ns, nrc;
    ls = m_s2[i];
    if (r) begin
      m_state[i] = HOLD; m_enter[i] = ec + 1; m_rc[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      return;
    end
    m_s2[i] = m_s1[i];
    m_s1[i] = lk;
    el  = ec - m_enter[i];
    ns  = m_state[i];
    nrc = m_rc[i];
    if (sf) begin
      ns = HOLD;
      if (m_state[i] == FLT) nrc = 0;
    end else begin
      case (m_state[i])
        HOLD: if (el == p_hold[i] - 1) ns = WAIT;
        WAIT: begin
          if (ls) ns = STAB;
          else if (el == p_tmo[i] - 1) begin
            if (m_rc[i] == p_maxr[i]) ns = FLT;
            else begin nrc = m_rc[i] + 1; ns = HOLD; end
          end
        end
        STAB: begin
          if (!ls) ns = WAIT;
          else if (el == p_stab[i] - 1) begin ns = RUN; nrc = 0; end
        end
        RUN: if (!ls) ns = HOLD;
        default: ;
      endcase
    end
    if (sf || ns != m_state[i]) m_enter[i] = ec + 1;
    m_state[i] = ns;
    m_rc[i] = nrc;
  endfunction

  function automatic logic [8:0] model_out(int i);
    int s;
    s = m_state[i];
    return {(s == HOLD) || (s == FLT), s != RUN, s == RUN, s == FLT, 2'(m_rc[i]), 3'(s)};
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step(0, rst, lock_a, soft_a);
    model_step(1, rst, lock_b, soft_b);
    ec++;
    @(negedge refclk);
  endtask

  task automatic do_reset(input bit la, input bit lb);
    rst = 1'b1; soft_a = 1'b0; soft_b = 1'b0; lock_a = la; lock_b = lb;
    repeat (5) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_a = 1'b0; soft_b = 1'b0; lock_a = 1'b1; lock_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== 9'b1_1_0_0_00_000) begin
          failures++;
          $display("FAIL reset dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], 9'b1_1_0_0_00_000);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL power_up_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      checks++;
      if (pll_rst_a !== (c < 16) || ready_a !== (c >= 81) || cpu_rst_a !== (c < 81) || rc_a !== 2'd0) begin
        failures++;
        $display("FAIL power_up_timing cyc=%0d got pll_rst=%b ready=%b cpu_rst=%b rc=%0d", c, pll_rst_a, ready_a, cpu_rst_a, rc_a);
      end
      tick();
    end
  endtask

  task automatic test_lock_glitch();
    int first_rdy;
    first_rdy = -1;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 180; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL glitch_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      if (ready_a && first_rdy < 0) first_rdy = c;
      checks++;
      if (rc_a !== 2'd0) begin
        failures++; $display("FAIL glitch_retry cyc=%0d got=%0d exp=0", c, rc_a);
      end
      lock_a = !(c >= 40 && c <= 42);
      tick();
    end
    checks++;
    if (first_rdy != 110) begin
      failures++; $display("FAIL glitch_ready_cycle got=%0d exp=110", first_rdy);
    end
  endtask

  task automatic test_run_lock_loss();
    int n_prst;
    n_prst = 0;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL run_loss_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      if (c >= 200 && pll_rst_a) n_prst++;
      if (c == 203) begin
        checks++;
        if (cpu_rst_a !== 1'b1 || ready_a !== 1'b0 || pll_rst_a !== 1'b1) begin
          failures++; $display("FAIL run_loss_response got cpu_rst=%b ready=%b pll_rst=%b exp 1 0 1", cpu_rst_a, ready_a, pll_rst_a);
        end
      end
      lock_a = !(c >= 200 && c < 210);
      tick();
    end
    checks++;
    if (n_prst != 16) begin
      failures++; $display("FAIL run_loss_pulse_width got=%0d exp=16", n_prst);
    end
    checks++;
    if (ready_a !== 1'b1) begin
      failures++; $display("FAIL run_loss_relock got ready=%b exp=1", ready_a);
    end
  endtask

  task automatic test_timeout_fault();
    int pulses;
    logic prev;
    pulses = 0; prev = 1'b0;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL timeout_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      if (pll_rst_b && !prev && !fault_b) pulses++;
      prev = pll_rst_b;
      checks++;
      if (cpu_rst_b !== 1'b1) begin
        failures++; $display("FAIL timeout_cpu_rst cyc=%0d got=%b exp=1", c, cpu_rst_b);
      end
      if (c == 20 || c == 50 || c == 90) begin
        checks++;
        if (rc_b !== 2'((c - 20) / 30)) begin
          failures++; $display("FAIL timeout_retry_step cyc=%0d got=%0d exp=%0d", c, rc_b, (c - 20) / 30);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 3 || fault_b !== 1'b1 || pll_rst_b !== 1'b1 || rc_b !== 2'd2) begin
      failures++;
      $display("FAIL timeout_fault got pulses=%0d fault=%b pll_rst=%b rc=%0d exp 3 1 1 2", pulses, fault_b, pll_rst_b, rc_b);
    end
  endtask

  task automatic test_fault_recovery();
    int first_rdy;
    first_rdy = -1;
    lock_b = 1'b1;
    repeat (5) tick();
    soft_b = 1'b1;
    tick();
    soft_b = 1'b0;
    checks++;
    if (fault_b !== 1'b0 || rc_b !== 2'd0 || st_b !== 3'd0) begin
      failures++; $display("FAIL recovery_clear got fault=%b rc=%0d state=%0d exp 0 0 0", fault_b, rc_b, st_b);
    end
    for (int k = 1; k <= 90; k++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL recovery_model dut%0d k=%0d got=%b exp=%b", i, k, obs[i], model_out(i));
        end
      end
      if (ready_b && first_rdy < 0) first_rdy = k;
      tick();
    end
    checks++;
    if (first_rdy != 70) begin
      failures++; $display("FAIL recovery_ready_cycle got=%0d exp=70", first_rdy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL simul_lock_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      if (c == 36) begin
        checks++;
        if (st_b !== 3'd2 || rc_b !== 2'd0) begin
          failures++; $display("FAIL simul_lock_vs_timeout got state=%0d rc=%0d exp 2 0", st_b, rc_b);
        end
      end
      lock_b = (c >= 33);
      tick();
    end
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 90; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL simul_soft_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
      end
      if (c == 81) begin
        checks++;
        if (ready_a !== 1'b0 || st_a !== 3'd0) begin
          failures++; $display("FAIL simul_soft_vs_run got ready=%b state=%0d exp 0 0", ready_a, st_a);
        end
      end
      soft_a = (c == 80);
      tick();
    end
    soft_a = 1'b0;
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== model_out(i)) begin
          failures++; $display("FAIL random_model dut%0d cyc=%0d got=%b exp=%b", i, c, obs[i], model_out(i));
        end
        checks++;
        if ((obs[i][8] && !obs[i][7]) || (obs[i][6] !== !obs[i][7]) || (obs[i][6] && obs[i][5])) begin
          failures++; $display("FAIL random_invariant dut%0d cyc=%0d got=%b", i, c, obs[i]);
        end
      end
      if ($urandom_range(0, 99) < 1) lock_a = ~lock_a;
      if ($urandom_range(0, 99) < 2) lock_b = ~lock_b;
      soft_a = ($urandom_range(0, 999) < 4);
      soft_b = ($urandom_range(0, 999) < 4);
      tick();
    end
    soft_a = 1'b0;
    soft_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; soft_a = 1'b0; soft_b = 1'b0; lock_a = 1'b1; lock_b = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_run_lock_loss();
    test_timeout_fault();
    test_fault_recovery();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
